apb_fanout: RTL and testbench

Parametrised APB fan-out for generated SoC tops. It takes one upstream APB slave port and routes each transfer to one of N_SLAVES downstream APB slaves by address-region decode. It registers the downstream request for timing. Unmapped addresses and stalled slaves complete upstream with PSLVERR, so a bad access never hangs the bus. It sits between the top-level APB port and the per-peripheral APB slaves, replacing hand-wired single-slave hookups.

---
 rtl/apb_fanout_if.sv | 46 ++++
 rtl/apb_fanout.sv | 115 +++++++++++
 tb/tb_apb_fanout.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_fanout_if.sv
// rtl/apb_fanout_if.sv - upstream APB port plus N-way downstream APB fan-out bundle
interface apb_fanout_if #(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0]          s_paddr;
    logic                       s_psel;
    logic                       s_penable;
    logic                       s_pwrite;
    logic [DATA_W-1:0]          s_pwdata;
    logic [STRB_W-1:0]          s_pstrb;
    logic [2:0]                 s_pprot;
    logic [DATA_W-1:0]          s_prdata;
    logic                       s_pready;
    logic                       s_pslverr;

    logic [ADDR_W-1:0]          m_paddr;
    logic [N_SLAVES-1:0]        m_psel;
    logic                       m_penable;
    logic                       m_pwrite;
    logic [DATA_W-1:0]          m_pwdata;
    logic [STRB_W-1:0]          m_pstrb;
    logic [2:0]                 m_pprot;
    logic [N_SLAVES*DATA_W-1:0] m_prdata;
    logic [N_SLAVES-1:0]        m_pready;
    logic [N_SLAVES-1:0]        m_pslverr;

    // Fan-out block's view: APB slave upstream, APB master downstream.
    modport slave (
        input  s_paddr, s_psel, s_penable, s_pwrite, s_pwdata, s_pstrb, s_pprot,
        output s_prdata, s_pready, s_pslverr,
        output m_paddr, m_psel, m_penable, m_pwrite, m_pwdata, m_pstrb, m_pprot,
        input  m_prdata, m_pready, m_pslverr
    );

    // Environment view: drives the upstream request and the downstream responses.
    modport master (
        output s_paddr, s_psel, s_penable, s_pwrite, s_pwdata, s_pstrb, s_pprot,
        input  s_prdata, s_pready, s_pslverr,
        input  m_paddr, m_psel, m_penable, m_pwrite, m_pwdata, m_pstrb, m_pprot,
        output m_prdata, m_pready, m_pslverr
    );
endinterface

// File: rtl/apb_fanout.sv
// rtl/apb_fanout.sv - APB 1:N fan-out with region decode, registered requests and stall timeout
module apb_fanout #(
    parameter int                N_SLAVES  = 4,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                REGION_W  = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    apb_fanout_if.slave bus
);
    localparam int IDX_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int HI_LSB = REGION_W + IDX_W;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [N_SLAVES-1:0] ONE_HOT0 = 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t           state;
    logic [IDX_W-1:0] lat_idx;
    logic [CNT_W-1:0] cnt;

    logic [IDX_W-1:0]  dec_idx;
    logic              dec_hit;
    logic              dec_mapped;
    logic              sel_ready;
    logic              sel_err;
    logic [DATA_W-1:0] sel_rdata;
    logic              timeout_hit;

    assign dec_idx    = bus.s_paddr[REGION_W +: IDX_W];
    assign dec_hit    = bus.s_paddr[ADDR_W-1:HI_LSB] == BASE_ADDR[ADDR_W-1:HI_LSB];
    assign dec_mapped = dec_hit && ({1'b0, dec_idx} < (IDX_W+1)'(N_SLAVES));

    assign sel_ready = bus.m_pready[lat_idx];
    assign sel_err   = bus.m_pslverr[lat_idx];
    assign sel_rdata = bus.m_prdata[lat_idx*DATA_W +: DATA_W];

    // Counter holds the number of wait cycles already spent in ACCESS.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lat_idx       <= '0;
            cnt           <= '0;
            bus.s_prdata  <= '0;
            bus.s_pready  <= 1'b0;
            bus.s_pslverr <= 1'b0;
            bus.m_paddr   <= '0;
            bus.m_psel    <= '0;
            bus.m_penable <= 1'b0;
            bus.m_pwrite  <= 1'b0;
            bus.m_pwdata  <= '0;
            bus.m_pstrb   <= '0;
            bus.m_pprot   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.s_psel && !bus.s_penable) begin
                        bus.m_paddr  <= bus.s_paddr;
                        bus.m_pwrite <= bus.s_pwrite;
                        bus.m_pwdata <= bus.s_pwdata;
                        bus.m_pstrb  <= bus.s_pstrb;
                        bus.m_pprot  <= bus.s_pprot;
                        lat_idx      <= dec_idx;
                        if (dec_mapped) begin
                            state      <= SETUP;
                            bus.m_psel <= ONE_HOT0 << dec_idx;
                        end else begin
                            // Nothing downstream to ask: answer with an error right away.
                            state         <= RESP;
                            bus.s_pready  <= 1'b1;
                            bus.s_pslverr <= 1'b1;
                            bus.s_prdata  <= '0;
                        end
                    end
                end
                SETUP: begin
                    state         <= ACCESS;
                    bus.m_penable <= 1'b1;
                    cnt           <= '0;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        state         <= RESP;
                        bus.m_psel    <= '0;
                        bus.m_penable <= 1'b0;
                        bus.s_pready  <= 1'b1;
                        bus.s_pslverr <= sel_err;
                        bus.s_prdata  <= bus.m_pwrite ? '0 : sel_rdata;
                    end else if (timeout_hit) begin
                        state         <= RESP;
                        bus.m_psel    <= '0;
                        bus.m_penable <= 1'b0;
                        bus.s_pready  <= 1'b1;
                        bus.s_pslverr <= 1'b1;
                        bus.s_prdata  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    bus.s_pready  <= 1'b0;
                    bus.s_pslverr <= 1'b0;
                    bus.s_prdata  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_fanout.sv
// tb/tb_apb_fanout.sv - directed vector bench for apb_fanout
module tb_apb_fanout;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int NEVER = 32'hFFFF;
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_fanout_if #(.N_SLAVES(4), .ADDR_W(32), .DATA_W(32)) u0 ();
    apb_fanout_if #(.N_SLAVES(4), .ADDR_W(32), .DATA_W(32)) u1 ();

    apb_fanout #(.N_SLAVES(4), .ADDR_W(32), .DATA_W(32), .REGION_W(12),
                 .BASE_ADDR(BASE), .TIMEOUT(8)) dut0 (.clk(clk), .rst(rst), .bus(u0));
    apb_fanout #(.N_SLAVES(4), .ADDR_W(32), .DATA_W(32), .REGION_W(12),
                 .BASE_ADDR(BASE), .TIMEOUT(0)) dut1 (.clk(clk), .rst(rst), .bus(u1));

    // Downstream slave models for dut0: configurable wait states, error and read data.
    int          wait_cfg [4] = '{0, 0, 0, 0};
    logic        err_cfg  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] rd_cfg   [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    int          wcnt     [4] = '{0, 0, 0, 0};
    logic [3:0]  s_rdy, s_err;
    logic [127:0] s_rd;

    always_comb begin
        s_rdy = '0;
        s_err = '0;
        s_rd  = '0;
        for (int i = 0; i < 4; i++) begin
            s_rdy[i] = u0.m_psel[i] && u0.m_penable && (wcnt[i] >= wait_cfg[i]);
            s_err[i] = s_rdy[i] && err_cfg[i];
            s_rd[i*32 +: 32] = rd_cfg[i];
        end
    end
    assign u0.m_pready  = s_rdy;
    assign u0.m_pslverr = s_err;
    assign u0.m_prdata  = s_rd;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (u0.m_psel[i] && u0.m_penable && !s_rdy[i]) wcnt[i] <= wcnt[i] + 1;
            else if (!(u0.m_psel[i] && u0.m_penable)) wcnt[i] <= 0;
        end
    end

    assign u1.m_pready  = 4'b0000;
    assign u1.m_pslverr = 4'b0000;
    assign u1.m_prdata  = '0;

    int checks = 0;
    int errors = 0;
    logic [31:0] mon_pwdata, mon_paddr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg_all(input int wt, input logic er, input int tgt, input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            wait_cfg[i] = wt;
            err_cfg[i]  = er;
            rd_cfg[i]   = 32'hEE00_0000 | i;
        end
        rd_cfg[tgt] = d;
    endtask

    // Full upstream transfer starting just after a rising edge; lat is the cycle index of s_pready.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic [3:0] seen, output int pen, output logic [3:0] busy_resp);
        u0.s_paddr = a; u0.s_pwrite = w; u0.s_pwdata = d; u0.s_pstrb = 4'hF; u0.s_pprot = 3'b010;
        u0.s_psel = 1'b1; u0.s_penable = 1'b0;
        rd = '0; er = 1'b0; lat = -1; seen = '0; pen = 0; busy_resp = '0;
        for (int c = 1; c <= LIMIT; c++) begin
            @(posedge clk); #1;
            u0.s_penable = 1'b1;
            @(negedge clk);
            seen |= u0.m_psel;
            if (u0.m_penable) begin
                pen++;
                mon_pwdata = u0.m_pwdata;
                mon_paddr  = u0.m_paddr;
            end
            if (u0.s_pready) begin
                rd = u0.s_prdata; er = u0.s_pslverr; lat = c;
                busy_resp = u0.m_psel | {3'b000, u0.m_penable};
                break;
            end
        end
        @(posedge clk); #1;
        u0.s_psel = 1'b0; u0.s_penable = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        int          wt;
        logic        serr;
        logic [3:0]  exp_sel;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_pen;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, pen;
        logic [3:0]  seen, busy;

        vecs[0]  = '{32'h4000_1004, 1'b1, 32'hDEADBEEF, 0, 1'b0, 4'b0010, 32'h0,        1'b0, 3,  1};
        vecs[1]  = '{32'h4000_3010, 1'b0, 32'h12345678, 2, 1'b0, 4'b1000, 32'h12345678, 1'b0, 5,  3};
        vecs[2]  = '{32'h4000_5000, 1'b0, 32'h11111111, 0, 1'b0, 4'b0000, 32'h0,        1'b1, 1,  0};
        vecs[3]  = '{32'h8000_0000, 1'b0, 32'h22222222, 0, 1'b0, 4'b0000, 32'h0,        1'b1, 1,  0};
        vecs[4]  = '{32'h4000_2008, 1'b0, 32'hAAAA5555, 0, 1'b1, 4'b0100, 32'hAAAA5555, 1'b1, 3,  1};
        vecs[5]  = '{32'h4000_0000, 1'b0, 32'h0BADF00D, 1, 1'b0, 4'b0001, 32'h0BADF00D, 1'b0, 4,  2};
        vecs[6]  = '{32'h4000_2000, 1'b1, 32'hC001D00D, 3, 1'b0, 4'b0100, 32'h0,        1'b0, 6,  4};
        vecs[7]  = '{32'h4000_1FFC, 1'b0, 32'h13579BDF, 0, 1'b0, 4'b0010, 32'h13579BDF, 1'b0, 3,  1};
        vecs[8]  = '{32'h3FFF_FFFC, 1'b0, 32'h33333333, 0, 1'b0, 4'b0000, 32'h0,        1'b1, 1,  0};
        vecs[9]  = '{32'h4000_1000, 1'b0, 32'hCAFE0007, 7, 1'b0, 4'b0010, 32'hCAFE0007, 1'b0, 10, 8};
        vecs[10] = '{32'h4000_0004, 1'b0, 32'hFFFF0008, 8, 1'b0, 4'b0001, 32'h0,        1'b1, 10, 8};
        vecs[11] = '{32'h4000_3000, 1'b1, 32'h55AA55AA, 0, 1'b1, 4'b1000, 32'h0,        1'b1, 3,  1};

        u0.s_paddr = '0; u0.s_psel = 0; u0.s_penable = 0; u0.s_pwrite = 0;
        u0.s_pwdata = '0; u0.s_pstrb = '0; u0.s_pprot = '0;
        u1.s_paddr = '0; u1.s_psel = 0; u1.s_penable = 0; u1.s_pwrite = 0;
        u1.s_pwdata = '0; u1.s_pstrb = '0; u1.s_pprot = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_s_pready",  u0.s_pready,  1'b0);
        chk("rst_s_pslverr", u0.s_pslverr, 1'b0);
        chk("rst_s_prdata",  u0.s_prdata,  32'h0);
        chk("rst_m_psel",    u0.m_psel,    4'b0000);
        chk("rst_m_penable", u0.m_penable, 1'b0);
        chk("rst_m_bus",     {u0.m_paddr, u0.m_pwdata}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Cycle-exact zero-wait write to slave 1
        cfg_all(0, 1'b0, 1, 32'h0);
        u0.s_paddr = BASE + 32'h1004; u0.s_pwrite = 1; u0.s_pwdata = 32'hDEADBEEF;
        u0.s_pstrb = 4'hF; u0.s_pprot = 3'b000; u0.s_psel = 1; u0.s_penable = 0;
        @(negedge clk);
        chk("t0_m_psel", u0.m_psel, 4'b0000);
        @(posedge clk); #1; u0.s_penable = 1;
        @(negedge clk);
        chk("t1_m_psel",    u0.m_psel,    4'b0010);
        chk("t1_m_penable", u0.m_penable, 1'b0);
        chk("t1_m_paddr",   u0.m_paddr,   BASE + 32'h1004);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_m_penable", u0.m_penable, 1'b1);
        chk("t2_m_pwdata",  u0.m_pwdata,  32'hDEADBEEF);
        chk("t2_s_pready",  u0.s_pready,  1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_s_pready",  u0.s_pready,  1'b1);
        chk("t3_s_pslverr", u0.s_pslverr, 1'b0);
        chk("t3_m_psel",    u0.m_psel,    4'b0000);
        @(posedge clk); #1; u0.s_psel = 0; u0.s_penable = 0;

        // Table of transfers, issued back to back
        for (int i = 0; i < 12; i++) begin
            cfg_all(vecs[i].wt, vecs[i].serr, int'(vecs[i].addr[13:12]), vecs[i].data);
            xfer(vecs[i].addr, vecs[i].wr, vecs[i].data, rd, er, lat, seen, pen, busy);
            chk($sformatf("v%0d_psel", i),  seen, vecs[i].exp_sel);
            chk($sformatf("v%0d_rdata", i), rd,   vecs[i].exp_rd);
            chk($sformatf("v%0d_err", i),   er,   vecs[i].exp_err);
            chk($sformatf("v%0d_lat", i),   lat,  vecs[i].exp_lat);
            chk($sformatf("v%0d_pen", i),   pen,  vecs[i].exp_pen);
            chk($sformatf("v%0d_idle_at_resp", i), busy, 4'b0000);
            if (vecs[i].exp_pen > 0) begin
                chk($sformatf("v%0d_m_paddr", i), mon_paddr, vecs[i].addr);
                if (vecs[i].wr) chk($sformatf("v%0d_m_pwdata", i), mon_pwdata, vecs[i].data);
            end
        end

        // Back-to-back write then read
        cfg_all(0, 1'b0, 2, 32'h600DCAFE);
        xfer(BASE + 32'h2010, 1'b1, 32'h0F0F0F0F, rd, er, lat, seen, pen, busy);
        chk("b2b_wr_lat", lat, 3);
        xfer(BASE + 32'h2014, 1'b0, 32'h0, rd, er, lat, seen, pen, busy);
        chk("b2b_rd_lat",   lat,  3);
        chk("b2b_rd_psel",  seen, 4'b0100);
        chk("b2b_rd_rdata", rd,   32'h600DCAFE);

        // Reset asserted during ACCESS
        cfg_all(NEVER, 1'b0, 0, 32'h0);
        u0.s_paddr = BASE; u0.s_pwrite = 1; u0.s_pwdata = 32'h0000_0011;
        u0.s_psel = 1; u0.s_penable = 0;
        @(posedge clk); #1; u0.s_penable = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstacc_pre_penable", u0.m_penable, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rstacc_m_psel",    u0.m_psel,    4'b0000);
        chk("rstacc_m_penable", u0.m_penable, 1'b0);
        chk("rstacc_m_bus",     {u0.m_paddr, u0.m_pwdata}, 64'h0);
        chk("rstacc_s_resp",    {u0.s_pready, u0.s_pslverr, u0.s_prdata}, 34'h0);
        u0.s_psel = 0; u0.s_penable = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        cfg_all(0, 1'b0, 0, 32'h0000600D);
        xfer(BASE + 32'h0008, 1'b0, 32'h0, rd, er, lat, seen, pen, busy);
        chk("post_rst_lat",   lat, 3);
        chk("post_rst_rdata", rd,  32'h0000600D);
        chk("post_rst_err",   er,  1'b0);

        // TIMEOUT=0 instance: a stalled slave is never aborted
        begin
            int saw_ready = 0;
            u1.s_paddr = BASE; u1.s_pwrite = 0; u1.s_psel = 1; u1.s_penable = 0;
            @(posedge clk); #1; u1.s_penable = 1;
            for (int c = 0; c < 1000; c++) begin
                @(negedge clk);
                if (u1.s_pready) saw_ready++;
            end
            chk("nto_no_ready", saw_ready, 0);
            chk("nto_m_psel",    u1.m_psel,    4'b0001);
            chk("nto_m_penable", u1.m_penable, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
